// File: rtl/method_call_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : method_call_sequencer
// Purpose  : Issues REPEAT calls to a downstream HLS-style method, after a
//            START_DELAY wait. Each call runs a req/busy handshake. The
//            return value is compared with a latched expected value. The
//            block counts passes and failures, flags timeouts and reports
//            the latency of the latest completed call.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   1          rising-edge clock
//   rst_n            in   1          asynchronous active-low reset
//   i_start          in   1          run start pulse (honoured in IDLE/DONE)
//   i_expect         in   RET_WIDTH  expected return, latched on start
//   o_method_req     out  1          call request (registered)
//   i_method_busy    in   1          downstream busy flag
//   i_method_return  in   RET_WIDTH  downstream return value
//   o_done           out  1          run finished
//   o_pass_count     out  16         calls whose return matched
//   o_fail_count     out  16         calls mismatched or timed out
//   o_timed_out      out  1          sticky: some call in the run timed out
//   o_last_latency   out  32         req rise to busy fall, latest call
// ============================================================================
module method_call_sequencer #(
  parameter int RET_WIDTH   = 32,
  parameter int START_DELAY = 100,
  parameter int TIMEOUT     = 100000,
  parameter int REPEAT      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [RET_WIDTH-1:0] i_expect,
  output logic                 o_method_req,
  input  logic                 i_method_busy,
  input  logic [RET_WIDTH-1:0] i_method_return,
  output logic                 o_done,
  output logic [15:0]          o_pass_count,
  output logic [15:0]          o_fail_count,
  output logic                 o_timed_out,
  output logic [31:0]          o_last_latency
);

  localparam logic [31:0] c_START_DELAY = 32'(START_DELAY);
  localparam logic [32:0] c_TIMEOUT     = 33'(TIMEOUT);
  localparam logic [16:0] c_REPEAT      = 17'(REPEAT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DELAY     = 3'd1,
    S_REQ       = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_CHECK     = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]          r_delay_cnt;
  logic [31:0]          r_lat_cnt;
  logic [31:0]          r_tmo_cnt;
  logic [15:0]          r_call_cnt;
  logic [RET_WIDTH-1:0] r_expect;
  logic [RET_WIDTH-1:0] r_ret;
  logic [15:0]          r_pass;
  logic [15:0]          r_fail;
  logic                 r_timed_out;
  logic [31:0]          r_last_lat;
  logic                 r_req;
  logic                 r_done;

  logic                 w_start_run;
  logic                 w_capture;
  logic                 w_timeout;
  logic                 w_check;
  logic                 w_wait_tmo;
  logic                 w_last_call;
  logic                 w_in_wait;
  logic [31:0]          w_lat_inc;

  // The current wait cycle is counted, so a call times out on its
  // TIMEOUT-th cycle in the wait states.
  assign w_wait_tmo  = ({1'b0, r_tmo_cnt} + 33'd1) >= c_TIMEOUT;
  // The call that finishes now is the REPEAT-th one.
  assign w_last_call = ({1'b0, r_call_cnt} + 17'd1) >= c_REPEAT;
  assign w_in_wait   = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  // The reported latency includes the cycle in which busy is seen low.
  assign w_lat_inc   = (r_lat_cnt == 32'hFFFF_FFFF) ? r_lat_cnt : r_lat_cnt + 32'd1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_start_run  = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_check      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_start_run  = 1'b1;
          w_next_state = S_DELAY;
        end
      end
      S_DELAY: begin
        // A loaded count of 0 or 1 both give a single DELAY cycle.
        if (r_delay_cnt <= 32'd1) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        w_next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (w_wait_tmo) begin
          w_timeout    = 1'b1;
          w_next_state = w_last_call ? S_DONE : S_REQ;
        end else if (i_method_busy) begin
          w_next_state = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (w_wait_tmo) begin
          w_timeout    = 1'b1;
          w_next_state = w_last_call ? S_DONE : S_REQ;
        end else if (!i_method_busy) begin
          w_capture    = 1'b1;
          w_next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        w_check      = 1'b1;
        w_next_state = w_last_call ? S_DONE : S_REQ;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delay_cnt <= '0;
      r_lat_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_call_cnt  <= '0;
      r_expect    <= '0;
      r_ret       <= '0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_timed_out <= 1'b0;
      r_last_lat  <= '0;
      r_req       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Decoding from the next state keeps req and done registered.
      r_req  <= (w_next_state == S_REQ) || (w_next_state == S_WAIT_BUSY);
      r_done <= (w_next_state == S_DONE);

      if (w_start_run) begin
        r_pass      <= '0;
        r_fail      <= '0;
        r_timed_out <= 1'b0;
        r_last_lat  <= '0;
        r_call_cnt  <= '0;
        r_expect    <= i_expect;
        r_delay_cnt <= c_START_DELAY;
      end else if (r_state == S_DELAY && r_delay_cnt != 32'd0) begin
        r_delay_cnt <= r_delay_cnt - 32'd1;
      end

      if (r_state == S_REQ) begin
        r_lat_cnt <= '0;
        r_tmo_cnt <= '0;
      end else if (w_in_wait) begin
        r_lat_cnt <= w_lat_inc;
        if (r_tmo_cnt != 32'hFFFF_FFFF) begin
          r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end
      end

      if (w_capture) begin
        r_ret      <= i_method_return;
        r_last_lat <= w_lat_inc;
      end

      if (w_timeout) begin
        r_timed_out <= 1'b1;
        if (r_fail != 16'hFFFF) r_fail <= r_fail + 16'd1;
      end

      if (w_check) begin
        if (r_ret == r_expect) begin
          if (r_pass != 16'hFFFF) r_pass <= r_pass + 16'd1;
        end else begin
          if (r_fail != 16'hFFFF) r_fail <= r_fail + 16'd1;
        end
      end

      if ((w_timeout || w_check) && r_call_cnt != 16'hFFFF) begin
        r_call_cnt <= r_call_cnt + 16'd1;
      end
    end
  end

  assign o_method_req   = r_req;
  assign o_done         = r_done;
  assign o_pass_count   = r_pass;
  assign o_fail_count   = r_fail;
  assign o_timed_out    = r_timed_out;
  assign o_last_latency = r_last_lat;

endmodule
`default_nettype wire
